// File: rtl/hwpe_stream_package.sv
// Shared HWPE-Stream definitions used by the TCDM responder.
//   HWPE_STREAM_TCDM_WORD_W : TCDM data word width (bits)
//   HWPE_STREAM_TCDM_BE_W   : TCDM byte-enable width
//   tcdm_resp_t             : one registered TCDM response (r_valid + r_data)
package hwpe_stream_package;

    localparam int unsigned HWPE_STREAM_TCDM_WORD_W = 32;
    localparam int unsigned HWPE_STREAM_TCDM_BE_W   = 4;

    typedef struct packed {
        logic        r_valid;
        logic [31:0] r_data;
    } tcdm_resp_t;

endpackage

// File: rtl/hwpe_stream_tcdm_bank_arbiter.sv
// Round-robin arbiter for one memory bank.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear of the round-robin pointer
//   stall_i       : when high, nothing is granted this cycle
//   req_i         : one bit per channel addressing this bank
//   gnt_o         : one-hot (or zero) grant vector, combinational
//   valid_o       : a grant was issued this cycle
//   winner_o      : index of the granted channel (meaningful when valid_o)
module hwpe_stream_tcdm_bank_arbiter #(
    parameter int unsigned NB_CHAN = 4,
    parameter int unsigned IDX_W   = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               stall_i,
    input  logic [NB_CHAN-1:0] req_i,
    output logic [NB_CHAN-1:0] gnt_o,
    output logic               valid_o,
    output logic [IDX_W-1:0]   winner_o
);

    localparam logic [IDX_W:0]   NB_CHAN_X = (IDX_W+1)'(NB_CHAN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB_CHAN - 1);

    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan channels starting at the pointer, wrapping modulo NB_CHAN;
    // the first requester found wins.
    always_comb begin
        gnt_o    = '0;
        valid_o  = 1'b0;
        winner_o = '0;
        sum      = '0;
        idx      = '0;
        if (!stall_i) begin
            for (int i = 0; i < NB_CHAN; i++) begin
                sum = {1'b0, rr_q} + (IDX_W+1)'(i);
                idx = (sum >= NB_CHAN_X) ? IDX_W'(sum - NB_CHAN_X) : IDX_W'(sum);
                if (!valid_o && req_i[idx]) begin
                    valid_o    = 1'b1;
                    winner_o   = idx;
                    gnt_o[idx] = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the winner; clear has priority over a grant.
    always_comb begin
        rr_d = rr_q;
        if (clear_i) begin
            rr_d = '0;
        end else if (valid_o) begin
            rr_d = (winner_o == LAST_IDX) ? '0 : winner_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// Memory-side endpoint of NB_CHAN TCDM channels over a word-interleaved,
// NB_BANKS-bank, NB_WORDS x 32-bit memory with one-cycle responses.
//   clk_i, rst_ni     : clock, asynchronous active-low reset (clears memory)
//   clear_i           : soft clear: pointers to 0, responses dropped, memory kept
//   stall_i[b]        : force bank b to grant nothing this cycle
//   tcdm_req_i ...    : per-channel request (add, wen=1 read / 0 write, be, data)
//   tcdm_gnt_o        : per-channel grant, combinational
//   tcdm_r_valid_o    : response valid one cycle after a grant
//   tcdm_r_data_o     : read word for reads, zero for writes and when idle
//
// Valid/ready semantics: a request is accepted in the cycle where req and gnt
// are both high; an ungranted request must be held stable by the master; each
// accepted request yields exactly one r_valid pulse in the following cycle
// unless clear_i or reset intervenes.
module hwpe_stream_tcdm_responder
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_CHAN  = 4,
    parameter int unsigned NB_BANKS = 2,
    parameter int unsigned NB_WORDS = 64
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            clear_i,
    input  logic [NB_BANKS-1:0]                             stall_i,
    input  logic [NB_CHAN-1:0]                              tcdm_req_i,
    input  logic [NB_CHAN-1:0][31:0]                        tcdm_add_i,
    input  logic [NB_CHAN-1:0]                              tcdm_wen_i,
    input  logic [NB_CHAN-1:0][HWPE_STREAM_TCDM_BE_W-1:0]   tcdm_be_i,
    input  logic [NB_CHAN-1:0][HWPE_STREAM_TCDM_WORD_W-1:0] tcdm_data_i,
    output logic [NB_CHAN-1:0]                              tcdm_gnt_o,
    output logic [NB_CHAN-1:0][HWPE_STREAM_TCDM_WORD_W-1:0] tcdm_r_data_o,
    output logic [NB_CHAN-1:0]                              tcdm_r_valid_o
);

    localparam int unsigned WORD_W = HWPE_STREAM_TCDM_WORD_W;
    localparam int unsigned BE_W   = HWPE_STREAM_TCDM_BE_W;
    localparam int unsigned ROWS   = NB_WORDS / NB_BANKS;
    localparam int unsigned LOG_B  = $clog2(NB_BANKS);
    localparam int unsigned BANK_W = (NB_BANKS > 1) ? LOG_B : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned IDX_W  = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;

    logic [NB_CHAN-1:0][BANK_W-1:0]  bank_idx;
    logic [NB_CHAN-1:0][ROW_W-1:0]   row_idx;
    logic [NB_BANKS-1:0][NB_CHAN-1:0] bank_req;
    logic [NB_BANKS-1:0][NB_CHAN-1:0] bank_gnt;
    logic [NB_BANKS-1:0]             bank_valid;
    logic [NB_BANKS-1:0][IDX_W-1:0]  bank_winner;
    logic [NB_BANKS-1:0]             bank_we;
    logic [NB_BANKS-1:0][ROW_W-1:0]  bank_row;
    logic [NB_BANKS-1:0][BE_W-1:0]   bank_be;
    logic [NB_BANKS-1:0][WORD_W-1:0] bank_wdata;
    logic [NB_CHAN-1:0]              gnt;

    logic [WORD_W-1:0] mem_q [NB_BANKS][ROWS];
    tcdm_resp_t [NB_CHAN-1:0] resp_d, resp_q;

    // Word-interleaved decode: low word-address bits pick the bank, the next
    // bits the row; byte offset and bits above the memory size are dropped.
    // Masking before truncation keeps the degenerate 1-bank / 1-row cases legal.
    always_comb begin
        for (int c = 0; c < NB_CHAN; c++) begin
            bank_idx[c] = BANK_W'((tcdm_add_i[c] >> 2) & 32'(NB_BANKS - 1));
            row_idx[c]  = ROW_W'((tcdm_add_i[c] >> (2 + LOG_B)) & 32'(ROWS - 1));
        end
    end

    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            for (int c = 0; c < NB_CHAN; c++) begin
                bank_req[b][c] = tcdm_req_i[c] && (bank_idx[c] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : gen_bank_arb
        hwpe_stream_tcdm_bank_arbiter #(
            .NB_CHAN (NB_CHAN),
            .IDX_W   (IDX_W)
        ) u_arb (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clear_i  (clear_i),
            .stall_i  (stall_i[b]),
            .req_i    (bank_req[b]),
            .gnt_o    (bank_gnt[b]),
            .valid_o  (bank_valid[b]),
            .winner_o (bank_winner[b])
        );
    end

    // Each channel maps to exactly one bank, so OR-ing per-bank grants is safe.
    // Grants are masked while reset is held.
    always_comb begin
        gnt = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            gnt = gnt | bank_gnt[b];
        end
        tcdm_gnt_o = gnt & {NB_CHAN{rst_ni}};
    end

    // Route the winning channel's write operands to its bank.
    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            bank_we[b]    = bank_valid[b] && !tcdm_wen_i[bank_winner[b]];
            bank_row[b]   = row_idx[bank_winner[b]];
            bank_be[b]    = tcdm_be_i[bank_winner[b]];
            bank_wdata[b] = tcdm_data_i[bank_winner[b]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NB_BANKS; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NB_BANKS; b++) begin
                if (bank_we[b]) begin
                    for (int k = 0; k < BE_W; k++) begin
                        if (bank_be[b][k]) begin
                            mem_q[b][bank_row[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Reads sample the pre-write row; a bank grants one channel per cycle, so a
    // read and a write to the same row can never coincide.
    always_comb begin
        for (int c = 0; c < NB_CHAN; c++) begin
            resp_d[c].r_valid = tcdm_gnt_o[c] && !clear_i;
            resp_d[c].r_data  = (tcdm_gnt_o[c] && !clear_i && tcdm_wen_i[c])
                              ? mem_q[bank_idx[c]][row_idx[c]] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NB_CHAN; c++) begin
            tcdm_r_valid_o[c] = resp_q[c].r_valid;
            tcdm_r_data_o[c]  = resp_q[c].r_data;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
module tb_hwpe_stream_tcdm_responder;

    localparam int NB_CHAN  = 4;
    localparam int NB_BANKS = 2;
    localparam int NB_WORDS = 64;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                      clear;
    logic [NB_BANKS-1:0]       stall;
    logic [NB_CHAN-1:0]        req, wen, gnt, r_valid;
    logic [NB_CHAN-1:0][31:0]  add, data, r_data;
    logic [NB_CHAN-1:0][3:0]   be;

    hwpe_stream_tcdm_responder #(
        .NB_CHAN  (NB_CHAN),
        .NB_BANKS (NB_BANKS),
        .NB_WORDS (NB_WORDS)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .stall_i        (stall),
        .tcdm_req_i     (req),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_be_i      (be),
        .tcdm_data_i    (data),
        .tcdm_gnt_o     (gnt),
        .tcdm_r_data_o  (r_data),
        .tcdm_r_valid_o (r_valid)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [NB_CHAN][$];
    logic [31:0] ref_mem [NB_WORDS];
    int          ref_rr  [NB_BANKS];
    logic [NB_CHAN-1:0] exp_gnt  = '0;
    logic [NB_CHAN-1:0] last_gnt = '0;
    logic [NB_CHAN-1:0] last_rvalid = '0;
    logic [31:0] last_rdata [NB_CHAN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % NB_WORDS);
    endfunction

    function automatic logic [NB_CHAN-1:0] predict_gnt();
        logic [NB_CHAN-1:0] g;
        g = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            if (!stall[b]) begin
                for (int k = 0; k < NB_CHAN; k++) begin
                    int c;
                    c = (ref_rr[b] + k) % NB_CHAN;
                    if (g == (g & ~(NB_CHAN'(1) << c)) && req[c] &&
                        (word_of(add[c]) % NB_BANKS) == b) begin
                        g[c] = 1'b1;
                        break;
                    end
                end
            end
        end
        return g;
    endfunction

    task automatic commit(input logic [NB_CHAN-1:0] g);
        logic [31:0] rd [NB_CHAN];
        for (int c = 0; c < NB_CHAN; c++) begin
            rd[c] = (g[c] && wen[c]) ? ref_mem[word_of(add[c])] : 32'h0;
        end
        for (int c = 0; c < NB_CHAN; c++) begin
            if (g[c] && !wen[c]) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[c][k]) ref_mem[word_of(add[c])][8*k +: 8] = data[c][8*k +: 8];
                end
            end
            if (g[c]) ref_rr[word_of(add[c]) % NB_BANKS] = (c + 1) % NB_CHAN;
            if (g[c] && !clear) exp_q[c].push_back(rd[c]);
        end
        if (clear) begin
            for (int b = 0; b < NB_BANKS; b++) ref_rr[b] = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        exp_gnt  = predict_gnt();
        last_gnt = gnt;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        @(posedge clk);
        commit(exp_gnt);
        #1;
    endtask

    task automatic set_ch(input int c, input logic r, input logic [31:0] a,
                          input logic w, input logic [3:0] b, input logic [31:0] d);
        req[c] = r; add[c] = a; wen[c] = w; be[c] = b; data[c] = d;
    endtask

    task automatic idle();
        req = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        stall = '0;
        for (int c = 0; c < NB_CHAN; c++) begin
            set_ch(c, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
            exp_q[c].delete();
        end
        for (int w = 0; w < NB_WORDS; w++) ref_mem[w] = 32'h0;
        for (int b = 0; b < NB_BANKS; b++) ref_rr[b] = 0;
        exp_gnt = '0;
        repeat (2) begin
            @(negedge clk);
            check("reset_gnt", 32'(gnt), 32'h0);
        end
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int c = 0; c < NB_CHAN; c++) begin
            logic has;
            has = (exp_q[c].size() != 0);
            check("r_valid", 32'(r_valid[c]), 32'(has));
            if (r_valid[c]) begin
                last_rdata[c] = r_data[c];
                if (has) check("r_data", r_data[c], exp_q[c].pop_front());
            end else begin
                check("idle_r_data", r_data[c], 32'h0);
                if (has) void'(exp_q[c].pop_front());
            end
        end
        last_rvalid = r_valid;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        clear = 1'b0;
        stall = '0;
        req = '0; add = '0; wen = '0; be = '0; data = '0;
        for (int c = 0; c < NB_CHAN; c++) last_rdata[c] = 32'h0;
        do_reset();

        // all four channels contend for bank 0 straight out of reset
        for (int c = 0; c < NB_CHAN; c++) set_ch(c, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_order", 32'(last_gnt), 32'(1 << i));
        end
        idle(); step();

        // full write then read back
        set_ch(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF); step();
        check("wr_gnt", 32'(last_gnt[0]), 32'h1);
        set_ch(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0); step();
        check("rd_gnt", 32'(last_gnt[0]), 32'h1);
        check("wr_resp_data", last_rdata[0], 32'h0);
        idle(); step();
        check("rd_data", last_rdata[0], 32'hDEADBEEF);

        // partial byte-enable write
        set_ch(0, 1'b1, 32'h10, 1'b0, 4'h3, 32'h11223344); step();
        set_ch(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0); step();
        idle(); step();
        check("partial_wr", last_rdata[0], 32'hDEAD3344);

        // two banks served in parallel
        set_ch(1, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
        set_ch(2, 1'b1, 32'h4, 1'b1, 4'h0, 32'h0);
        step();
        check("par_gnt", 32'(last_gnt), 32'h6);
        idle(); step();
        check("par_rvalid", 32'(last_rvalid & 4'b0110), 32'h6);

        // bank 0 stalled for three cycles
        stall = 2'b01;
        set_ch(0, 1'b1, 32'h8, 1'b1, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_gnt", 32'(last_gnt[0]), 32'h0);
        end
        stall = 2'b00;
        step();
        check("stall_release", 32'(last_gnt[0]), 32'h1);
        idle(); step();
        check("stall_rvalid", 32'(last_rvalid[0]), 32'h1);

        // clear drops the response and rewinds the pointer
        set_ch(2, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0); step();
        idle();
        set_ch(1, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
        clear = 1'b1; step(); clear = 1'b0;
        for (int c = 0; c < NB_CHAN; c++) set_ch(c, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
        step();
        check("clear_rvalid", 32'(last_rvalid[1]), 32'h0);
        check("clear_rr", 32'(last_gnt), 32'h1);
        idle(); step();

        // reset wipes memory
        set_ch(0, 1'b1, 32'h20, 1'b0, 4'hF, 32'hCAFEF00D); step();
        set_ch(0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0); step();
        idle(); step();
        check("pre_reset", last_rdata[0], 32'hCAFEF00D);
        do_reset();
        set_ch(0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0); step();
        idle(); step();
        check("post_reset", last_rdata[0], 32'h0);

        // randomized traffic; ungranted requests are held stable
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NB_CHAN; c++) begin
                int w;
                if (req[c] && !exp_gnt[c]) continue;
                w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NB_WORDS - 1);
                set_ch(c, $urandom_range(0, 2) != 0,
                       ($urandom() & 32'hFFFF_FF00) | (32'(w) << 2) | 32'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 4'($urandom()), $urandom());
            end
            stall = ($urandom_range(0, 3) == 0) ? NB_BANKS'($urandom()) : '0;
            clear = ($urandom_range(0, 40) == 0);
            if (n == 300) do_reset();
            step();
        end
        clear = 1'b0;
        stall = '0;
        idle();
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
